// File: rtl/fifo_push_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared definitions for the fifo_push_arb block: the arbiter FSM state type,
//   the payload width, and a constant-friendly clog2 used to size the credit
//   counter, the round-robin pointer and the burst counter.
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    localparam int DATA_W = 64;

    // LOCKED is only ever entered when FIFO_ARB_LOCK_EN is defined.
    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Smallest r with (1 << r) >= value; returns at least 1 so that
    // vectors sized from it never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fifo_push_arb_if.sv
// -----------------------------------------------------------------------------
// fifo_push_arb_if
//   Bundles the producer side, the FIFO write side and the status outputs of
//   fifo_push_arb.
//
//   master : the arbiter (reads req/req_data/req_lock/pop, drives the rest)
//   slave  : the producers + FIFO environment
//
//   Signals:
//     req        [NREQ]        per-requester push request
//     req_data   [NREQ*64]     payloads, requester i at [64i+63:64i]
//     req_lock   [NREQ]        per-requester burst-lock request
//     pop                      FIFO pop strobe, returns one credit
//     grant      [NREQ]        registered one-hot grant
//     fifo_data_in [64]        registered push data
//     fifo_data_in_valid       registered push strobe
//     credits    [clog2(DEPTH+1)] free FIFO entries
//     err                      sticky credit underflow/overflow
//     dbg_state                current arbiter FSM state
//
//   Handshake: a requester raises req[i] with its payload and holds both
//   stable until it observes grant[i] = 1. grant[i] means the payload that
//   was presented in the previous cycle has been pushed. In the grant cycle
//   the requester may drop req[i] or present new data for another push.
// -----------------------------------------------------------------------------
interface fifo_push_arb_if
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 4
);
    localparam int CRED_W = clog2(DEPTH + 1);

    logic [NREQ-1:0]        req;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_lock;
    logic                   pop;
    logic [NREQ-1:0]        grant;
    logic [DATA_W-1:0]      fifo_data_in;
    logic                   fifo_data_in_valid;
    logic [CRED_W-1:0]      credits;
    logic                   err;
    arb_state_e             dbg_state;

    modport master (
        input  req, req_data, req_lock, pop,
        output grant, fifo_data_in, fifo_data_in_valid, credits, err, dbg_state
    );

    modport slave (
        output req, req_data, req_lock, pop,
        input  grant, fifo_data_in, fifo_data_in_valid, credits, err, dbg_state
    );

endinterface

// File: rtl/fifo_push_arb_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin priority picker: returns the first set bit of
//   req_i searching upward from ptr_i, wrapping modulo NREQ.
//
//   req_i     [NREQ]   candidate requests
//   ptr_i     [PTR_W]  highest-priority position (0..NREQ-1)
//   win_oh_o  [NREQ]   one-hot winner (zero when nothing requested)
//   win_idx_o [PTR_W]  binary winner index (zero when nothing requested)
//   any_o              a winner exists
// -----------------------------------------------------------------------------
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int PTR_W = clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [PTR_W-1:0] win_idx_o,
    output logic             any_o
);

    logic [PTR_W:0] cand;
    logic           found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            // ptr_i < NREQ, so one conditional subtract is enough to wrap.
            cand = {1'b0, ptr_i} + (PTR_W + 1)'(k);
            if (cand >= (PTR_W + 1)'(NREQ)) begin
                cand = cand - (PTR_W + 1)'(NREQ);
            end
            if (!found && req_i[cand[PTR_W-1:0]]) begin
                found                     = 1'b1;
                win_oh_o[cand[PTR_W-1:0]] = 1'b1;
                win_idx_o                 = cand[PTR_W-1:0];
            end
        end
    end

    assign any_o = found;

endmodule

// File: rtl/fifo_push_arb.sv
// -----------------------------------------------------------------------------
// fifo_push_arb
//   Round-robin arbiter sharing one 64-bit FIFO write port among NREQ
//   producers. A credit counter mirrors FIFO occupancy so a push is only
//   issued when the FIFO can take it (a pop in the same cycle counts).
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-low reset
//     bus   fifo_push_arb_if.master (requests, pop, grant, FIFO write, status)
//
//   Parameters: NREQ (2..8), DEPTH (FIFO entries = credits), MAX_BURST.
//
//   Optional feature macro FIFO_ARB_LOCK_EN: a winner holding req_lock keeps
//   the port (LOCKED state) for up to MAX_BURST consecutive grants. Without
//   the macro req_lock is ignored and the FSM stays in ARB.
// -----------------------------------------------------------------------------
module fifo_push_arb
    import fifo_arb_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DEPTH     = 4,
    parameter int MAX_BURST = 4
) (
    input logic             clk,
    input logic             rst,
    fifo_push_arb_if.master bus
);

    localparam int CRED_W = clog2(DEPTH + 1);
    localparam int PTR_W  = clog2(NREQ);

    logic [NREQ-1:0]   grant_q,   grant_d;
    logic [DATA_W-1:0] data_q,    data_d;
    logic              valid_q,   valid_d;
    logic [CRED_W-1:0] credits_q, credits_d;
    logic              err_q,     err_d;
    logic [PTR_W-1:0]  rr_ptr_q,  rr_ptr_d;
    arb_state_e        state_q,   state_d;

    logic [NREQ-1:0]   req_ok;
    logic [NREQ-1:0]   win_oh;
    logic [PTR_W-1:0]  pick_ptr;
    logic [PTR_W-1:0]  win_idx;
    logic [PTR_W-1:0]  sel_idx;
    logic [DATA_W-1:0] sel_data;
    logic              win_any;
    logic              can_push;
    logic              lock_hold;
    logic              push;
    logic              pop_ok;

`ifdef FIFO_ARB_LOCK_EN
    localparam int BURST_W = clog2(MAX_BURST + 1);
    logic [PTR_W-1:0]   lock_idx_q, lock_idx_d;
    logic [BURST_W-1:0] burst_q,    burst_d;
`else
    logic unused_lock;
    assign unused_lock = ^bus.req_lock;
`endif

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NREQ - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Pre-arbitration: candidate mask, credit availability, lock hold.
    always_comb begin
        // The requester granted last cycle is still showing the old req/data
        // during this decision, so it sits out to avoid a double push.
        req_ok    = bus.req & ~grant_q;
        can_push  = (credits_q != '0) || bus.pop;
        pick_ptr  = rr_ptr_q;
        lock_hold = 1'b0;
`ifdef FIFO_ARB_LOCK_EN
        if (state_q == LOCKED) begin
            // A locked requester streams: a held req means "another beat",
            // so it is not subject to the one-cycle exclusion above.
            if (bus.req[lock_idx_q] && bus.req_lock[lock_idx_q] &&
                (burst_q < BURST_W'(MAX_BURST))) begin
                lock_hold = 1'b1;
            end else begin
                // Leaving the lock: the rest of the ring gets first chance
                // starting just after the locked requester, this cycle.
                pick_ptr = ptr_inc(lock_idx_q);
            end
        end
`endif
    end

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req_i     (req_ok),
        .ptr_i     (pick_ptr),
        .win_oh_o  (win_oh),
        .win_idx_o (win_idx),
        .any_o     (win_any)
    );

    // Payload mux for whichever requester is being pushed this cycle.
    always_comb begin
        sel_idx = win_idx;
`ifdef FIFO_ARB_LOCK_EN
        if (lock_hold) begin
            sel_idx = lock_idx_q;
        end
`endif
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (sel_idx == PTR_W'(k)) begin
                sel_data = bus.req_data[k*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state: FSM, grant/data registers, credit counter, error flag.
    always_comb begin
        grant_d   = '0;
        data_d    = data_q;
        valid_d   = 1'b0;
        push      = 1'b0;
        rr_ptr_d  = pick_ptr;
        state_d   = state_q;
        err_d     = err_q;
        credits_d = credits_q;
        pop_ok    = bus.pop && (credits_q != CRED_W'(DEPTH));
`ifdef FIFO_ARB_LOCK_EN
        lock_idx_d = lock_idx_q;
        burst_d    = burst_q;
        if ((state_q == LOCKED) && !lock_hold) begin
            state_d = ARB;
            burst_d = '0;
        end
`endif

        if (lock_hold) begin
            // A credit stall simply skips the beat; the lock is kept.
            if (can_push) begin
                push             = 1'b1;
                grant_d[sel_idx] = 1'b1;
`ifdef FIFO_ARB_LOCK_EN
                burst_d = burst_q + BURST_W'(1);
`endif
            end
        end else if (can_push && win_any) begin
            push     = 1'b1;
            grant_d  = win_oh;
            rr_ptr_d = ptr_inc(win_idx);
`ifdef FIFO_ARB_LOCK_EN
            if (bus.req_lock[win_idx]) begin
                state_d    = LOCKED;
                lock_idx_d = win_idx;
                burst_d    = BURST_W'(1);
            end
`endif
        end

        if (push) begin
            data_d  = sel_data;
            valid_d = 1'b1;
        end

        // A pop with every entry already free is ignored but flagged.
        if (bus.pop && !pop_ok) begin
            err_d = 1'b1;
        end
        if (push && !pop_ok) begin
            if (credits_q == '0) begin
                err_d = 1'b1;
            end else begin
                credits_d = credits_q - CRED_W'(1);
            end
        end else if (!push && pop_ok) begin
            credits_d = credits_q + CRED_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            credits_q <= CRED_W'(DEPTH);
            err_q     <= 1'b0;
            rr_ptr_q  <= '0;
            state_q   <= ARB;
`ifdef FIFO_ARB_LOCK_EN
            lock_idx_q <= '0;
            burst_q    <= '0;
`endif
        end else begin
            grant_q   <= grant_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            credits_q <= credits_d;
            err_q     <= err_d;
            rr_ptr_q  <= rr_ptr_d;
            state_q   <= state_d;
`ifdef FIFO_ARB_LOCK_EN
            lock_idx_q <= lock_idx_d;
            burst_q    <= burst_d;
`endif
        end
    end

    assign bus.grant              = grant_q;
    assign bus.fifo_data_in       = data_q;
    assign bus.fifo_data_in_valid = valid_q;
    assign bus.credits            = credits_q;
    assign bus.err                = err_q;
    assign bus.dbg_state          = state_q;

endmodule
